// File: rtl/mdio_poller.sv
// mdio_poller: autonomous Wishbone master that periodically reads two PHY
// registers through the MDIO controller and caches a coherent snapshot.
module mdio_poller #(
    parameter logic [31:0] POLL_INTERVAL = 32'd2_000_000,
    parameter logic [15:0] TIMEOUT       = 16'd4095,
    parameter logic [4:0]  REG_A         = 5'h01,
    parameter logic [4:0]  REG_B         = 5'h10,
    parameter int unsigned LINK_BIT      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pause,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_addr,
    output logic [15:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data,
    output logic [15:0] o_reg_a,
    output logic [15:0] o_reg_b,
    output logic        o_valid,
    output logic        o_link_up,
    output logic        o_int,
    output logic        o_err,
    output logic        o_idle
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_REQ_A,
        S_ACK_A,
        S_REQ_B,
        S_ACK_B
    } state_t;

    localparam logic [31:0] RELOAD  = POLL_INTERVAL - 32'd1;
    localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;
    localparam logic [3:0]  LB      = LINK_BIT[3:0];

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] to_q, to_d;
    logic        first_q, first_d;
    logic [15:0] shadow_q, shadow_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] reg_a_q, reg_a_d;
    logic [15:0] reg_b_q, reg_b_d;
    logic        valid_q, valid_d;
    logic        link_q, link_d;
    logic        int_q, int_d;
    logic        err_q, err_d;
    logic        idle_q, idle_d;
    logic        to_hit;
    logic        unused_hi;

    // Only the low half of the read data carries the PHY register.
    assign unused_hi = ^i_wb_data[31:16];

    // Timeout fires on the clock the counter has seen TIMEOUT ack-less cycles.
    assign to_hit = (to_q >= TO_LAST);

    // Next-state and next-output computation for the poll sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        first_d  = first_q;
        shadow_d = shadow_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        addr_d   = addr_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        valid_d  = valid_q;
        err_d    = err_q;
        int_d    = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 32'd0) begin
                    if (!i_pause) begin
                        state_d = S_REQ_A;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        addr_d  = REG_A;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_REQ_A: begin
                if (!i_wb_stall) begin
                    state_d = S_ACK_A;
                    stb_d   = 1'b0;
                    to_d    = 16'd0;
                end
            end
            S_ACK_A: begin
                if (i_wb_ack) begin
                    shadow_d = i_wb_data[15:0];
                    state_d  = S_REQ_B;
                    stb_d    = 1'b1;
                    addr_d   = REG_B;
                end else if (to_hit) begin
                    state_d = S_WAIT;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = RELOAD;
                end else begin
                    to_d = to_q + 16'd1;
                end
            end
            S_REQ_B: begin
                if (!i_wb_stall) begin
                    state_d = S_ACK_B;
                    stb_d   = 1'b0;
                    to_d    = 16'd0;
                end
            end
            S_ACK_B: begin
                if (i_wb_ack) begin
                    reg_a_d = shadow_q;
                    reg_b_d = i_wb_data[15:0];
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    int_d   = first_q |
                              ({shadow_q, i_wb_data[15:0]} !=
                               {reg_a_q, reg_b_q});
                    first_d = 1'b0;
                    state_d = S_WAIT;
                    cyc_d   = 1'b0;
                    cnt_d   = RELOAD;
                end else if (to_hit) begin
                    state_d = S_WAIT;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = RELOAD;
                end else begin
                    to_d = to_q + 16'd1;
                end
            end
            default: begin
                state_d = S_WAIT;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                cnt_d   = RELOAD;
            end
        endcase
        link_d = valid_d & reg_a_d[LB];
        idle_d = (state_d == S_WAIT) & ~cyc_d;
    end

    // State and registered outputs; reset aborts any bus cycle at once.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_WAIT;
            cnt_q    <= RELOAD;
            to_q     <= 16'd0;
            first_q  <= 1'b1;
            shadow_q <= 16'd0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            addr_q   <= 5'd0;
            reg_a_q  <= 16'd0;
            reg_b_q  <= 16'd0;
            valid_q  <= 1'b0;
            link_q   <= 1'b0;
            int_q    <= 1'b0;
            err_q    <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            first_q  <= first_d;
            shadow_q <= shadow_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            addr_q   <= addr_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            valid_q  <= valid_d;
            link_q   <= link_d;
            int_q    <= int_d;
            err_q    <= err_d;
            idle_q   <= idle_d;
        end
    end

    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = 1'b0;
    assign o_wb_addr = addr_q;
    assign o_wb_data = 16'd0;
    assign o_reg_a   = reg_a_q;
    assign o_reg_b   = reg_b_q;
    assign o_valid   = valid_q;
    assign o_link_up = link_q;
    assign o_int     = int_q;
    assign o_err     = err_q;
    assign o_idle    = idle_q;

endmodule
